// File: rtl/icb_dbg_arbiter_pkg.sv
// Shared types, widths and master IDs for the core/debug ICB arbiter.
// Optional feature macro: ICB_ARB_RR_EN (round-robin arbitration instead of debug-first priority).
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef MemBus
`define MemBus 31:0
`endif

package icb_dbg_arbiter_pkg;

    localparam logic ICB_ARB_ID_CORE = 1'b0;
    localparam logic ICB_ARB_ID_DBG  = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } icb_cmd_t;

endpackage

// File: rtl/icb_arb_id_fifo.sv
// One-bit-wide ID FIFO recording which master owns each outstanding ICB command.
module icb_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == (AW+1)'(0));
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = id_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/icb_dbg_arbiter.sv
// Two-master (core LSU / JTAG debug) to one-slave ICB arbiter with zero-latency pass-through.
// Macro ICB_ARB_RR_EN selects round-robin; default build gives the debug master priority.
module icb_dbg_arbiter
    import icb_dbg_arbiter_pkg::*;
#(
    parameter int OST_DEPTH = 2,
    parameter int OST_AW    = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_cmd_valid,
    output logic              m0_cmd_ready,
    input  logic [`MemAddrBus] m0_cmd_addr,
    input  logic              m0_cmd_read,
    input  logic [`MemBus]    m0_cmd_wdata,
    input  logic [3:0]        m0_cmd_wmask,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic              m0_rsp_err,
    output logic [`MemBus]    m0_rsp_rdata,

    input  logic              m1_cmd_valid,
    output logic              m1_cmd_ready,
    input  logic [`MemAddrBus] m1_cmd_addr,
    input  logic              m1_cmd_read,
    input  logic [`MemBus]    m1_cmd_wdata,
    input  logic [3:0]        m1_cmd_wmask,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic              m1_rsp_err,
    output logic [`MemBus]    m1_rsp_rdata,

    output logic              s_cmd_valid,
    input  logic              s_cmd_ready,
    output logic [`MemAddrBus] s_cmd_addr,
    output logic              s_cmd_read,
    output logic [`MemBus]    s_cmd_wdata,
    output logic [3:0]        s_cmd_wmask,
    input  logic              s_rsp_valid,
    output logic              s_rsp_ready,
    input  logic              s_rsp_err,
    input  logic [`MemBus]    s_rsp_rdata
);

    logic     lock_q, lock_d;
    logic     owner_q, owner_d;
    logic     grant_s, gnt_valid_s;
    logic     fifo_full_s, fifo_empty_s, fifo_head_s;
    logic     push_s, pop_s, sel_rsp_ready_s;
    icb_cmd_t m0_cmd_s, m1_cmd_s, gnt_cmd_s;
`ifdef ICB_ARB_RR_EN
    logic     rr_last_q, rr_last_d;
`endif

    assign m0_cmd_s = '{addr: m0_cmd_addr, read: m0_cmd_read, wdata: m0_cmd_wdata, wmask: m0_cmd_wmask};
    assign m1_cmd_s = '{addr: m1_cmd_addr, read: m1_cmd_read, wdata: m1_cmd_wdata, wmask: m1_cmd_wmask};

    // Grant selection; a stalled command keeps its owner until the handshake completes
    always_comb begin
        grant_s = ICB_ARB_ID_CORE;
        if (lock_q) begin
            grant_s = owner_q;
        end else if (m0_cmd_valid && m1_cmd_valid) begin
`ifdef ICB_ARB_RR_EN
            grant_s = ~rr_last_q;
`else
            grant_s = ICB_ARB_ID_DBG;
`endif
        end else if (m1_cmd_valid) begin
            grant_s = ICB_ARB_ID_DBG;
        end else begin
            grant_s = ICB_ARB_ID_CORE;
        end
    end

    assign gnt_valid_s  = (grant_s == ICB_ARB_ID_DBG) ? m1_cmd_valid : m0_cmd_valid;
    assign gnt_cmd_s    = (grant_s == ICB_ARB_ID_DBG) ? m1_cmd_s : m0_cmd_s;

    assign s_cmd_valid  = gnt_valid_s & ~fifo_full_s;
    assign s_cmd_addr   = gnt_cmd_s.addr;
    assign s_cmd_read   = gnt_cmd_s.read;
    assign s_cmd_wdata  = gnt_cmd_s.wdata;
    assign s_cmd_wmask  = gnt_cmd_s.wmask;

    assign m0_cmd_ready = gnt_valid_s & (grant_s == ICB_ARB_ID_CORE) & s_cmd_ready & ~fifo_full_s;
    assign m1_cmd_ready = gnt_valid_s & (grant_s == ICB_ARB_ID_DBG)  & s_cmd_ready & ~fifo_full_s;

    assign push_s = s_cmd_valid & s_cmd_ready;
    assign pop_s  = s_rsp_valid & s_rsp_ready;

    // Responses go only to the owner recorded at the FIFO head; nothing is forwarded when empty
    assign sel_rsp_ready_s = (fifo_head_s == ICB_ARB_ID_DBG) ? m1_rsp_ready : m0_rsp_ready;
    assign s_rsp_ready     = ~fifo_empty_s & sel_rsp_ready_s;
    assign m0_rsp_valid    = s_rsp_valid & ~fifo_empty_s & (fifo_head_s == ICB_ARB_ID_CORE);
    assign m1_rsp_valid    = s_rsp_valid & ~fifo_empty_s & (fifo_head_s == ICB_ARB_ID_DBG);
    assign m0_rsp_err      = s_rsp_err;
    assign m1_rsp_err      = s_rsp_err;
    assign m0_rsp_rdata    = s_rsp_rdata;
    assign m1_rsp_rdata    = s_rsp_rdata;

    // Lock tracking
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (push_s) begin
            lock_d  = 1'b0;
            owner_d = owner_q;
        end else if (s_cmd_valid && !s_cmd_ready) begin
            lock_d  = 1'b1;
            owner_d = grant_s;
        end else begin
            lock_d  = lock_q;
            owner_d = owner_q;
        end
    end

    // Lock state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= 1'b0;
            owner_q <= ICB_ARB_ID_CORE;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

`ifdef ICB_ARB_RR_EN
    // Remember the last master served so the other one wins the next tie
    always_comb begin
        rr_last_d = rr_last_q;
        if (push_s) begin
            rr_last_d = grant_s;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= ICB_ARB_ID_CORE;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    icb_arb_id_fifo #(
        .DEPTH (OST_DEPTH),
        .AW    (OST_AW)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .id_i    (grant_s),
        .pop_i   (pop_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .head_o  (fifo_head_s)
    );

endmodule

// File: tb/tb_icb_dbg_arbiter.sv
// Directed and randomized bench for icb_dbg_arbiter against a queue-based ownership model.
module tb_icb_dbg_arbiter;

    localparam int OST = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
    logic [3:0]  m1_cmd_wmask;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
    logic [3:0]  s_cmd_wmask;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: queue of owners of outstanding commands, the master a stalled command belongs to, last served
    int q[$];
    int stuck = -1;
    int last  = 0;

    always #5 clk = ~clk;

    icb_dbg_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_addr(m0_cmd_addr),
        .m0_cmd_read(m0_cmd_read), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_err(m0_rsp_err),
        .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_addr(m1_cmd_addr),
        .m1_cmd_read(m1_cmd_read), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_err(m1_rsp_err),
        .m1_rsp_rdata(m1_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_err(s_rsp_err),
        .s_rsp_rdata(s_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int exp_grant();
        if (stuck >= 0) return stuck;
        if (m0_cmd_valid && m1_cmd_valid) begin
`ifdef ICB_ARB_RR_EN
            return (last == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return m1_cmd_valid ? 1 : 0;
    endfunction

    // Check all outputs against the model for the current inputs, clock once, update the model
    task automatic cycle();
        int   g, head;
        logic gv, full, cmd_hs, rsp_hs, sel_rdy, ne;
        #1;
        g    = exp_grant();
        gv   = (g == 1) ? m1_cmd_valid : m0_cmd_valid;
        full = (q.size() >= OST);
        ne   = (q.size() > 0);
        head = ne ? q[0] : 0;
        chk("s_cmd_valid", s_cmd_valid, gv && !full);
        if (gv && !full) begin
            chk("s_cmd_addr",  s_cmd_addr,  (g == 1) ? m1_cmd_addr  : m0_cmd_addr);
            chk("s_cmd_read",  s_cmd_read,  (g == 1) ? m1_cmd_read  : m0_cmd_read);
            chk("s_cmd_wdata", s_cmd_wdata, (g == 1) ? m1_cmd_wdata : m0_cmd_wdata);
            chk("s_cmd_wmask", s_cmd_wmask, (g == 1) ? m1_cmd_wmask : m0_cmd_wmask);
        end
        chk("m0_cmd_ready", m0_cmd_ready, (g == 0) && gv && s_cmd_ready && !full);
        chk("m1_cmd_ready", m1_cmd_ready, (g == 1) && gv && s_cmd_ready && !full);
        sel_rdy = (head == 1) ? m1_rsp_ready : m0_rsp_ready;
        chk("s_rsp_ready",  s_rsp_ready,  ne && sel_rdy);
        chk("m0_rsp_valid", m0_rsp_valid, s_rsp_valid && ne && head == 0);
        chk("m1_rsp_valid", m1_rsp_valid, s_rsp_valid && ne && head == 1);
        chk("m0_rsp_rdata", m0_rsp_rdata, s_rsp_rdata);
        chk("m1_rsp_rdata", m1_rsp_rdata, s_rsp_rdata);
        chk("m0_rsp_err",   m0_rsp_err,   s_rsp_err);
        chk("m1_rsp_err",   m1_rsp_err,   s_rsp_err);
        cmd_hs = gv && !full && s_cmd_ready;
        rsp_hs = s_rsp_valid && ne && sel_rdy;
        @(posedge clk);
        if (rsp_hs) void'(q.pop_front());
        if (cmd_hs) begin
            q.push_back(g);
            last  = g;
            stuck = -1;
        end else if (gv && !full) begin
            stuck = g;
        end
        #1;
        if (cmd_hs && g == 0) m0_cmd_valid = 1'b0;
        if (cmd_hs && g == 1) m1_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        s_cmd_ready  = 1'b1;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0 && !m0_cmd_valid && !m1_cmd_valid) break;
            s_rsp_valid = (q.size() > 0);
            s_rsp_rdata = $urandom;
            cycle();
        end
        s_rsp_valid = 1'b0;
        chk("drain_done", 32'(q.size()) + {31'd0, m0_cmd_valid} + {31'd0, m1_cmd_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {m0_cmd_valid, m0_cmd_read, m0_rsp_ready, m1_cmd_valid, m1_cmd_read, m1_rsp_ready} = 6'd0;
        {m0_cmd_addr, m0_cmd_wdata, m1_cmd_addr, m1_cmd_wdata} = 128'd0;
        {m0_cmd_wmask, m1_cmd_wmask} = 8'd0;
        {s_cmd_ready, s_rsp_valid, s_rsp_err} = 3'd0;
        s_rsp_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_cmd_valid", s_cmd_valid, 1'b0);
        chk("rst_m0_cmd_ready", m0_cmd_ready, 1'b0);
        chk("rst_m1_cmd_ready", m1_cmd_ready, 1'b0);
        chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);
        chk("rst_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
        rst_n = 1'b1;

        // 1: single core read and routed response
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 32'h8000_0000; s_cmd_ready = 1'b1;
        cycle();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h1234_5678; m0_rsp_ready = 1'b1;
        #1;
        chk("t1_m0_rsp_valid", m0_rsp_valid, 1'b1);
        chk("t1_m1_rsp_valid", m1_rsp_valid, 1'b0);
        chk("t1_rdata", m0_rsp_rdata, 32'h1234_5678);
        cycle();
        s_rsp_valid = 1'b0;

        // 2: simultaneous requests, debug first then core
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h0000_1000; m0_cmd_read = 1'b0; m0_cmd_wdata = 32'hA5A5_0001; m0_cmd_wmask = 4'hF;
        m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h0000_2000; m1_cmd_read = 1'b1;
        #1;
        chk("t2_first_m1", {m1_cmd_ready, m0_cmd_ready}, 2'b10);
        chk("t2_first_addr", s_cmd_addr, 32'h0000_2000);
        cycle();
        #1;
        chk("t2_second_m0", {m1_cmd_ready, m0_cmd_ready}, 2'b01);
        cycle();
        drain();

        // 3: stalled slave keeps grant and fields stable while debug requests
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h2000_0010; s_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h3000_0000; end
            #1;
            chk("t3_addr_stable", s_cmd_addr, 32'h2000_0010);
            chk("t3_m1_blocked", m1_cmd_ready, 1'b0);
            cycle();
        end
        s_cmd_ready = 1'b1;
        #1;
        chk("t3_m0_accept", m0_cmd_ready, 1'b1);
        cycle();
        cycle();

        // 4: two outstanding, third command stalls
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h4000_0000;
        #1;
        chk("t4_full_stall", {s_cmd_valid, m0_cmd_ready}, 2'b00);
        cycle();

        // 5: pop and push in the same full cycle: push waits one cycle
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hCAFE_0000;
        #1;
        chk("t5_blocked", m0_cmd_ready, 1'b0);
        chk("t5_rsp_m0", m0_rsp_valid, 1'b1);
        cycle();
        s_rsp_valid = 1'b0;
        #1;
        chk("t5_next_accept", m0_cmd_ready, 1'b1);
        cycle();
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h4000_0004;
        #1;
        chk("t5_count2", s_cmd_valid, 1'b0);
        s_rsp_valid = 1'b1;
        #1;
        chk("t4_order_m1", {m1_rsp_valid, m0_rsp_valid}, 2'b10);
        cycle();
        drain();

        // 6: reset with one outstanding drops the late response
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h5000_0000;
        cycle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        q.delete(); stuck = -1; last = 0;
        s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        #1;
        chk("t6_rsp_ready", s_rsp_ready, 1'b0);
        chk("t6_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
        cycle();
        s_rsp_valid = 1'b0;

        // Randomized traffic with protocol-abiding masters and slave
        for (int i = 0; i < 400; i++) begin
            if (!m0_cmd_valid && $urandom_range(0, 2) == 0) begin
                m0_cmd_valid = 1'b1; m0_cmd_addr = $urandom; m0_cmd_read = 1'($urandom_range(0, 1));
                m0_cmd_wdata = $urandom; m0_cmd_wmask = 4'($urandom_range(0, 15));
            end
            if (!m1_cmd_valid && $urandom_range(0, 2) == 0) begin
                m1_cmd_valid = 1'b1; m1_cmd_addr = $urandom; m1_cmd_read = 1'($urandom_range(0, 1));
                m1_cmd_wdata = $urandom; m1_cmd_wmask = 4'($urandom_range(0, 15));
            end
            s_cmd_ready  = ($urandom_range(0, 3) != 0);
            s_rsp_valid  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rsp_rdata  = $urandom;
            s_rsp_err    = 1'($urandom_range(0, 1));
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
